// File: rtl/quad_step_decoder_if.sv
// quad_step_decoder_if: control inputs and step/position outputs of the quadrature decoder
interface quad_step_decoder_if #(
    parameter int CNT_W = 4
);
    logic             en;
    logic             clr;
    logic             a_in;
    logic             b_in;
    logic             step;
    logic             dir;
    logic [CNT_W-1:0] count;
    logic             wrap;
    logic             err;

    modport master (output en, clr, a_in, b_in, input step, dir, count, wrap, err);
    modport slave  (input en, clr, a_in, b_in, output step, dir, count, wrap, err);
endinterface

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronised, glitch-filtered quadrature decoder with wrapping position count
module quad_step_decoder #(
    parameter int CNT_W    = 4,
    parameter int FILT_LEN = 3
) (
    input  logic               clk,
    input  logic               rst,
    quad_step_decoder_if.slave io_bus
);
    localparam int            RW = $clog2(FILT_LEN + 1);
    localparam logic [RW-1:0] FL = RW'(FILT_LEN);

    logic [1:0]       r_s1, r_s2, r_last, r_filt, r_state;
    logic [RW-1:0]    r_run, w_run_nxt;
    logic             r_fv, r_fupd, r_init;
    logic             w_accept, w_up, w_dn, w_bad, w_legal, w_wrap;
    logic             r_step, r_dir, r_wrap, r_err;
    logic [CNT_W-1:0] r_count;

    // Run length of identical synchronised samples; accept a new value once it has held FILT_LEN edges
    always_comb begin
        w_run_nxt = (r_s2 != r_last) ? RW'(1) : (r_run == FL) ? r_run : r_run + RW'(1);
        w_accept  = (w_run_nxt == FL) && (!r_fv || r_s2 != r_filt);
    end

    // Classify the accepted value against the last decoder state (Gray up: 00->01->11->10)
    always_comb begin
        w_up    = r_fupd && !r_init && (r_filt == {r_state[0], ~r_state[1]});
        w_dn    = r_fupd && !r_init && (r_filt == {~r_state[0], r_state[1]});
        w_bad   = r_fupd && !r_init && (r_filt == ~r_state);
        w_legal = (w_up || w_dn) && io_bus.en;
        w_wrap  = w_up ? &r_count : ~|r_count;
    end

    // Two-flop synchroniser and glitch filter; r_fupd marks the edge a value was accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_last <= '0;
            r_run  <= '0;
            r_filt <= '0;
            r_fv   <= 1'b0;
            r_fupd <= 1'b0;
        end else begin
            r_s1   <= {io_bus.a_in, io_bus.b_in};
            r_s2   <= r_s1;
            r_last <= r_s2;
            r_run  <= w_run_nxt;
            r_fupd <= w_accept;
            if (w_accept) begin
                r_filt <= r_s2;
                r_fv   <= 1'b1;
            end
        end
    end

    // Decoder state and registered outputs; clr overrides count/err/wrap but not step/dir
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_init  <= 1'b1;
            r_step  <= 1'b0;
            r_dir   <= 1'b1;
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (r_fupd) begin
                r_state <= r_filt;
                r_init  <= 1'b0;
            end
            r_step <= w_legal;
            if (w_legal)
                r_dir <= w_up;
            r_count <= io_bus.clr ? '0 : w_legal ? (w_up ? r_count + CNT_W'(1) : r_count - CNT_W'(1)) : r_count;
            r_wrap  <= !io_bus.clr && w_legal && w_wrap;
            r_err   <= !io_bus.clr && (r_err || w_bad);
        end
    end

    assign io_bus.step  = r_step;
    assign io_bus.dir   = r_dir;
    assign io_bus.count = r_count;
    assign io_bus.wrap  = r_wrap;
    assign io_bus.err   = r_err;
endmodule
